// File: rtl/pe_writer_pkg.sv
// Shared FSM encoding and default sizing for the PE result writer.
package pe_writer_pkg;

    localparam int DEF_NUM_LANES   = 64;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 15;
    localparam int DEF_ADDR_STRIDE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

endpackage

// File: rtl/pe_writer_slot.sv
// One vector slot: captures a result vector with optional ReLU and lane-count clamp.
module pe_writer_slot
    import pe_writer_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int CNT_W     = $clog2(NUM_LANES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cap_i,
    input  logic                        clr_i,
    input  logic                        relu_i,
    input  logic [NUM_LANES*DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0]           base_i,
    input  logic [CNT_W-1:0]            count_i,
    output logic [NUM_LANES*DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0]           base_o,
    output logic [CNT_W-1:0]            count_o,
    output logic                        valid_o
);

    logic [NUM_LANES*DATA_W-1:0] data_d, data_q;
    logic [CNT_W-1:0]            count_d, count_q;
    logic [ADDR_W-1:0]           base_q;
    logic                        valid_q;

    // ReLU and clamp are idempotent, so re-capturing an already processed vector is harmless.
    always_comb begin
        data_d = data_i;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (relu_i && data_i[i*DATA_W + DATA_W - 1]) begin
                data_d[i*DATA_W +: DATA_W] = '0;
            end
        end
        count_d = (count_i > CNT_W'(NUM_LANES)) ? CNT_W'(NUM_LANES) : count_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            base_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else if (cap_i) begin
            data_q  <= data_d;
            base_q  <= base_i;
            count_q <= count_d;
            valid_q <= 1'b1;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign base_o  = base_q;
    assign count_o = count_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pe_output_writer.sv
// Streams a captured PE result vector lane by lane onto a stallable write bus,
// with one pending slot so the next vector can be queued during a write.
module pe_output_writer
    import pe_writer_pkg::*;
#(
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int ADDR_STRIDE = DEF_ADDR_STRIDE
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_LANES*DATA_W-1:0]        datain_pe,
    input  logic                               load,
    input  logic [ADDR_W-1:0]                  base_addr,
    input  logic [$clog2(NUM_LANES+1)-1:0]     lane_count,
    input  logic                               relu_en,
    output logic                               ready,
    output logic                               busy,
    output logic                               done,
    output logic [ADDR_W-1:0]                  address_output,
    output logic [DATA_W-1:0]                  writedata_output,
    output logic                               write_output,
    output logic [DATA_W/8-1:0]                byteenable_output,
    output logic                               chipselect,
    input  logic                               waitrequest_output
);

    localparam int CNT_W = $clog2(NUM_LANES + 1);

    wr_state_e                   state_q;
    logic [CNT_W-1:0]            idx_q;
    logic [ADDR_W-1:0]           off_q;
    logic                        done_q;

    logic [NUM_LANES*DATA_W-1:0] act_data, pnd_data, src_data;
    logic [ADDR_W-1:0]           act_base, pnd_base, src_base;
    logic [CNT_W-1:0]            act_cnt, pnd_cnt, src_cnt;
    logic                        act_vld, pnd_vld, src_relu;
    logic                        accept, cap_act, cap_pnd, promote;
    logic [DATA_W-1:0]           lane_sel;

    assign ready   = !pnd_vld;
    assign accept  = load && ready;
    assign promote = (state_q == ST_IDLE) && pnd_vld;
    assign cap_act = accept && (state_q == ST_IDLE);
    assign cap_pnd = accept && (state_q != ST_IDLE);

    // ACTIVE loads either straight from the inputs or from PENDING on promotion.
    assign src_data = promote ? pnd_data : datain_pe;
    assign src_base = promote ? pnd_base : base_addr;
    assign src_cnt  = promote ? pnd_cnt  : lane_count;
    assign src_relu = promote ? 1'b0     : relu_en;

    pe_writer_slot #(
        .NUM_LANES(NUM_LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) u_active (
        .clk(clk), .rst(rst),
        .cap_i(cap_act || promote), .clr_i(state_q == ST_DONE), .relu_i(src_relu),
        .data_i(src_data), .base_i(src_base), .count_i(src_cnt),
        .data_o(act_data), .base_o(act_base), .count_o(act_cnt), .valid_o(act_vld)
    );

    pe_writer_slot #(
        .NUM_LANES(NUM_LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) u_pending (
        .clk(clk), .rst(rst),
        .cap_i(cap_pnd), .clr_i(promote), .relu_i(relu_en),
        .data_i(datain_pe), .base_i(base_addr), .count_i(lane_count),
        .data_o(pnd_data), .base_o(pnd_base), .count_o(pnd_cnt), .valid_o(pnd_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    // Clamping never turns a zero count non-zero, so the raw count decides.
                    if (cap_act || promote) begin
                        idx_q   <= '0;
                        off_q   <= '0;
                        state_q <= (src_cnt == '0) ? ST_DONE : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!waitrequest_output) begin
                        if (idx_q + CNT_W'(1) == act_cnt) begin
                            idx_q   <= '0;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q <= idx_q + CNT_W'(1);
                            off_q <= off_q + ADDR_W'(ADDR_STRIDE);
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lane_sel = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (int'(idx_q) == i) lane_sel = act_data[i*DATA_W +: DATA_W];
        end
    end

    assign write_output      = (state_q == ST_WRITE);
    assign chipselect        = write_output;
    assign byteenable_output = {(DATA_W/8){write_output}};
    assign address_output    = write_output ? (act_base + off_q) : '0;
    assign writedata_output  = write_output ? lane_sel : '0;
    assign done              = done_q;
    assign busy              = (state_q != ST_IDLE) || act_vld || pnd_vld;

endmodule

// File: tb/tb_pe_output_writer.sv
// Self-checking bench for pe_output_writer with NUM_LANES=4.
module tb_pe_output_writer;

    localparam int NL = 4;
    localparam int DW = 16;
    localparam int AW = 15;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [NL*DW-1:0] datain_pe;
    logic           load;
    logic [AW-1:0]  base_addr;
    logic [CW-1:0]  lane_count;
    logic           relu_en;
    logic           ready, busy, done;
    logic [AW-1:0]  address_output;
    logic [DW-1:0]  writedata_output;
    logic           write_output;
    logic [DW/8-1:0] byteenable_output;
    logic           chipselect;
    logic           waitrequest_output;

    pe_output_writer #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW), .ADDR_STRIDE(1)) dut (
        .clk(clk), .rst(rst), .datain_pe(datain_pe), .load(load), .base_addr(base_addr),
        .lane_count(lane_count), .relu_en(relu_en), .ready(ready), .busy(busy), .done(done),
        .address_output(address_output), .writedata_output(writedata_output),
        .write_output(write_output), .byteenable_output(byteenable_output),
        .chipselect(chipselect), .waitrequest_output(waitrequest_output)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    int            obs_cyc[$];
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];
    int done_cnt = 0, done_cyc = 0;
    int stall_beat = -1, stall_len = 0, stall_used = 0;
    bit rand_stall = 1'b0;

    typedef struct packed {
        logic [63:0] lanes;
        logic [14:0] base;
        logic [2:0]  cnt;
        logic        relu;
        int          sb;
        int          sl;
        int          n;
        logic [59:0] ea;
        logic [63:0] ed;
        int          lat;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [63:0] lanes, logic [14:0] base, logic [2:0] cnt, logic relu,
                                int sb, int sl, int n, logic [59:0] ea, logic [63:0] ed, int lat);
        vec_t v;
        v.lanes = lanes; v.base = base; v.cnt = cnt; v.relu = relu; v.sb = sb; v.sl = sl;
        v.n = n; v.ea = ea; v.ed = ed; v.lat = lat;
        return v;
    endfunction

    // Reference: the bus sees min(count, NL) words, addresses wrap mod 2^AW, negatives zeroed under ReLU.
    task automatic model_push(input logic [63:0] lanes, input logic [14:0] base, input int cnt, input logic relu);
        int n;
        logic [15:0] w;
        n = (cnt > NL) ? NL : cnt;
        for (int i = 0; i < n; i++) begin
            w = lanes[i*16 +: 16];
            exp_a.push_back(AW'((int'(base) + i) % 32768));
            exp_d.push_back((relu && w >= 16'h8000) ? 16'h0 : w);
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    endtask

    task automatic monitor();
        logic hold = 1'b0;
        logic wr;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        forever begin
            @(negedge clk);
            if (rst) begin
                waitrequest_output = 1'b0;
                hold = 1'b0;
                continue;
            end
            if (write_output) begin
                if (rand_stall) wr = ($urandom_range(0, 3) == 0);
                else wr = (obs_addr.size() == stall_beat) && (stall_used < stall_len);
                if (wr) stall_used++;
                waitrequest_output = wr;
                if (hold) begin
                    chk("hold_addr", address_output, pa);
                    chk("hold_data", writedata_output, pd);
                end
                chk("wr_byteen", byteenable_output, 2'b11);
                chk("wr_cs", chipselect, 1);
                if (!wr) begin
                    obs_addr.push_back(address_output);
                    obs_data.push_back(writedata_output);
                    obs_cyc.push_back(cyc);
                end
                hold = wr; pa = address_output; pd = writedata_output;
            end else begin
                waitrequest_output = 1'b0;
                hold = 1'b0;
                chk("idle_data", writedata_output, 0);
                chk("idle_byteen", byteenable_output, 0);
                chk("idle_cs", chipselect, 0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int t0, d0;
        clear_obs();
        stall_beat = v.sb; stall_len = v.sl; stall_used = 0;
        d0 = done_cnt;
        @(negedge clk);
        datain_pe = v.lanes; base_addr = v.base; lane_count = v.cnt; relu_en = v.relu; load = 1'b1;
        t0 = cyc;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 40 && done_cnt == d0; k++) @(negedge clk);
        chk({nm, "_done_count"}, done_cnt - d0, 1);
        chk({nm, "_latency"}, done_cyc - t0, v.lat);
        chk({nm, "_beats"}, obs_addr.size(), v.n);
        if (v.n > 0 && v.sb != 0 && obs_cyc.size() > 0) chk({nm, "_first_beat"}, obs_cyc[0] - t0, 1);
        for (int i = 0; i < v.n; i++) begin
            if (i < obs_addr.size()) begin
                chk({nm, "_addr"}, obs_addr[i], v.ea[i*15 +: 15]);
                chk({nm, "_data"}, obs_data[i], v.ed[i*16 +: 16]);
            end
        end
        @(negedge clk);
        chk({nm, "_done_pulse_end"}, done, 0);
        chk({nm, "_ready_after"}, ready, 1);
        chk({nm, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int d0, nrst, accepted;
        logic [63:0] rl;
        logic [14:0] rb;
        int rc;
        logic rr;

        tbl[0] = mk(64'h0004_0003_0002_0001, 15'h10, 3'd4, 1'b0, -1, 0, 4,
                    {15'h13, 15'h12, 15'h11, 15'h10}, 64'h0004_0003_0002_0001, 6);
        tbl[1] = mk(64'h7FFF_8000_0005_FFFF, 15'h20, 3'd4, 1'b1, -1, 0, 4,
                    {15'h23, 15'h22, 15'h21, 15'h20}, 64'h7FFF_0000_0005_0000, 6);
        tbl[2] = mk(64'hDDDD_CCCC_BBBB_AAAA, 15'h40, 3'd4, 1'b0, 1, 3, 4,
                    {15'h43, 15'h42, 15'h41, 15'h40}, 64'hDDDD_CCCC_BBBB_AAAA, 9);
        tbl[3] = mk(64'h1234_5678_9ABC_DEF0, 15'h50, 3'd0, 1'b0, -1, 0, 0,
                    60'h0, 64'h0, 2);
        tbl[4] = mk(64'h0044_0033_0022_0011, 15'h60, 3'd7, 1'b0, -1, 0, 4,
                    {15'h63, 15'h62, 15'h61, 15'h60}, 64'h0044_0033_0022_0011, 6);
        tbl[5] = mk(64'h0000_0000_2222_1111, 15'h7FFF, 3'd2, 1'b0, -1, 0, 2,
                    {15'h0, 15'h0, 15'h0000, 15'h7FFF}, 64'h0000_0000_2222_1111, 4);
        tbl[6] = mk(64'h8001_0000_FFFF_1234, 15'h1000, 3'd3, 1'b0, -1, 0, 3,
                    {15'h0, 15'h1002, 15'h1001, 15'h1000}, 64'h8001_0000_FFFF_1234, 5);

        rst = 1'b1; load = 1'b0; datain_pe = '0; base_addr = '0; lane_count = '0;
        relu_en = 1'b0; waitrequest_output = 1'b0;
        fork monitor(); join_none
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_write", write_output, 0);
        chk("rst_addr", address_output, 0);
        chk("rst_byteen", byteenable_output, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back: A runs, B queues, C is refused while B waits.
        clear_obs(); stall_beat = -1; stall_len = 0; stall_used = 0;
        d0 = done_cnt;
        @(negedge clk);
        datain_pe = 64'h000A_000A_000A_000A; base_addr = 15'h100; lane_count = 3'd4; relu_en = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        chk("b2b_ready_before_b", ready, 1);
        datain_pe = 64'h000B_000B_000B_000B; base_addr = 15'h200; load = 1'b1;
        @(negedge clk);
        chk("b2b_ready_low", ready, 0);
        chk("b2b_busy", busy, 1);
        datain_pe = 64'h000C_000C_000C_000C; base_addr = 15'h300;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 60 && (done_cnt - d0) < 2; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("b2b_done_count", done_cnt - d0, 2);
        chk("b2b_beats", obs_addr.size(), 8);
        for (int i = 0; i < 8 && i < obs_addr.size(); i++) begin
            chk("b2b_addr", obs_addr[i], (i < 4) ? (15'h100 + 15'(i)) : (15'h200 + 15'(i - 4)));
            chk("b2b_data", obs_data[i], (i < 4) ? 16'h000A : 16'h000B);
        end
        if (obs_cyc.size() >= 5) chk("b2b_gap", obs_cyc[4] - obs_cyc[3], 3);

        // Reset in the middle of a vector.
        clear_obs(); stall_beat = -1; stall_used = 0;
        d0 = done_cnt;
        @(negedge clk);
        datain_pe = 64'h0004_0003_0002_0001; base_addr = 15'h700; lane_count = 3'd4; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 20 && obs_addr.size() < 2; k++) @(negedge clk);
        @(posedge clk);
        #2;
        chk("rst_mid_write_before", write_output, 1);
        nrst = obs_addr.size();
        rst = 1'b1;
        #1;
        chk("rst_mid_write", write_output, 0);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", address_output, 0);
        chk("rst_mid_cs", chipselect, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_more_beats", obs_addr.size(), nrst);
        chk("rst_ready_after", ready, 1);

        // Randomized stream with random stalls against the reference queue.
        clear_obs(); exp_a.delete(); exp_d.delete();
        rand_stall = 1'b1;
        d0 = done_cnt;
        accepted = 0;
        for (int k = 0; k < 800 && accepted < 20; k++) begin
            @(negedge clk);
            load = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                rl = {$urandom, $urandom};
                rb = 15'($urandom_range(0, 32767));
                rc = $urandom_range(0, 7);
                rr = 1'($urandom_range(0, 1));
                datain_pe = rl; base_addr = rb; lane_count = 3'(rc); relu_en = rr; load = 1'b1;
                if (ready) begin
                    model_push(rl, rb, rc, rr);
                    accepted++;
                end
            end
        end
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 600 && (done_cnt - d0) < accepted; k++) @(negedge clk);
        rand_stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("rand_done_count", done_cnt - d0, accepted);
        chk("rand_beats", obs_addr.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < obs_addr.size(); i++) begin
            chk("rand_addr", obs_addr[i], exp_a[i]);
            chk("rand_data", obs_data[i], exp_d[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
